// File: rtl/uart_tx_serializer_if.sv
// Parallel-byte handshake into the UART transmitter and the serial line/Busy coming back out.
// The master drives the byte and frame options; the slave returns the line and its Busy status.
interface uart_tx_serializer_if #(
    parameter int Data_Width = 8
);
    logic [Data_Width-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, LSB-first data, optional parity, stop; one bit per CLK.
// Latency: start bit on TX_OUT the cycle after Data_Valid is accepted in IDLE.
// Backpressure: Busy high for the whole frame; Data_Valid outside IDLE is dropped, never queued.
module uart_tx_serializer #(
    parameter int Data_Width = 8,
    parameter int B_C_W      = $clog2(Data_Width)
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_serializer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [B_C_W-1:0] LAST_IDX = B_C_W'(Data_Width - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [B_C_W-1:0]        idx;
    logic [B_C_W-1:0]        idx_nxt;
    logic [Data_Width-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_bit_q;
    logic                    accept;
    logic                    tx_q;
    logic                    tx_nxt;
    logic                    busy_q;
    logic                    busy_nxt;

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            tx_q   <= tx_nxt;
            busy_q <= busy_nxt;
            if (accept) begin
                data_q    <= bus.P_DATA;
                par_en_q  <= bus.PAR_EN;
                par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                idx_nxt   = '0;
                state_nxt = DATA;
            end
            DATA: begin
                if (idx == LAST_IDX) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Outputs are flopped, so decode them from the state being entered.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[idx_nxt];
            PARITY:  tx_nxt = par_bit_q;
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: directed vector table, corner-case sequences and random frames vs a queue model.
module tb_uart_tx_serializer;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;

    uart_tx_serializer_if #(.Data_Width(W)) bus ();

    uart_tx_serializer #(.Data_Width(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic tx;
        logic busy;
    } exp_t;

    typedef struct {
        logic [W-1:0] data;
        bit           pen;
        bit           ptyp;
        bit           exp_par;
        int           exp_len;
        int           mode;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   busy_cnt;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %b, want %b", name, idx, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic push(input logic tx, input logic busy);
        exp_t e;
        e.tx   = tx;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1, Busy high throughout.
    task automatic add_frame(input logic [W-1:0] d, input bit pen, input bit par_bit);
        push(1'b0, 1'b1);
        for (int b = 0; b < W; b++) push(d[b], 1'b1);
        if (pen) push(par_bit, 1'b1);
        push(1'b1, 1'b1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] d, input bit pen, input bit ptyp, input bit hold);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Data_Valid = 1'b1;
        step();
        if (!hold) bus.Data_Valid = 1'b0;
    endtask

    // Mode 1: disturb byte/options mid-frame. 2: stray Data_Valid pulse in DATA.
    // 3: drop a held Data_Valid once the second frame's start bit is out.
    task automatic run_expect(input string name, input int mode);
        busy_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check({name, ".tx"}, i, bus.TX_OUT, exp_q[i].tx);
            check({name, ".busy"}, i, bus.Busy, exp_q[i].busy);
            if (bus.Busy === 1'b1) busy_cnt++;
            if (mode == 1 && i == 3) begin
                bus.P_DATA  = 8'hFF;
                bus.PAR_EN  = 1'b0;
                bus.PAR_TYP = ~bus.PAR_TYP;
            end
            if (mode == 2 && i == 4) begin
                bus.P_DATA     = 8'hC3;
                bus.Data_Valid = 1'b1;
            end
            if (mode == 2 && i == 5) bus.Data_Valid = 1'b0;
            if (mode == 3 && i == 0) bus.P_DATA = 8'hAA;
            if (mode == 3 && i == 11) bus.Data_Valid = 1'b0;
            step();
        end
        exp_q.delete();
    endtask

    initial begin
        RST            = 1'b1;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        step();
        step();
        check("reset.tx", 0, bus.TX_OUT, 1'b1);
        check("reset.busy", 0, bus.Busy, 1'b0);
        RST = 1'b0;
        step();
        check("idle.tx", 0, bus.TX_OUT, 1'b1);

        vecs[0] = '{data: 8'hA5, pen: 0, ptyp: 0, exp_par: 0, exp_len: 10, mode: 0};
        vecs[1] = '{data: 8'hA5, pen: 1, ptyp: 0, exp_par: 0, exp_len: 11, mode: 0};
        vecs[2] = '{data: 8'hA5, pen: 1, ptyp: 1, exp_par: 1, exp_len: 11, mode: 0};
        vecs[3] = '{data: 8'h07, pen: 1, ptyp: 0, exp_par: 1, exp_len: 11, mode: 1};
        vecs[4] = '{data: 8'h3C, pen: 0, ptyp: 0, exp_par: 0, exp_len: 10, mode: 2};

        for (int v = 0; v < 5; v++) begin
            add_frame(vecs[v].data, vecs[v].pen, vecs[v].exp_par);
            push(1'b1, 1'b0);
            push(1'b1, 1'b0);
            accept(vecs[v].data, vecs[v].pen, vecs[v].ptyp, 1'b0);
            run_expect($sformatf("vec%0d", v), vecs[v].mode);
            check_int($sformatf("vec%0d.busy_len", v), busy_cnt, vecs[v].exp_len);
        end

        // Back-to-back frames with Data_Valid held: exactly one idle cycle between them.
        add_frame(8'h55, 1'b0, 1'b0);
        push(1'b1, 1'b0);
        add_frame(8'hAA, 1'b0, 1'b0);
        push(1'b1, 1'b0);
        push(1'b1, 1'b0);
        accept(8'h55, 1'b0, 1'b0, 1'b1);
        run_expect("b2b", 3);
        check_int("b2b.busy_len", busy_cnt, 20);

        // Reset during data bit 4 of 8'h0F aborts the frame.
        add_frame(8'h0F, 1'b0, 1'b0);
        accept(8'h0F, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            check("abort.tx", i, bus.TX_OUT, exp_q[i].tx);
            if (i < 5) step();
        end
        exp_q.delete();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("abort.rst_tx", 0, bus.TX_OUT, 1'b1);
        check("abort.rst_busy", 0, bus.Busy, 1'b0);
        step();
        check("abort.idle_busy", 0, bus.Busy, 1'b0);
        add_frame(8'h0F, 1'b0, 1'b0);
        push(1'b1, 1'b0);
        accept(8'h0F, 1'b0, 1'b0, 1'b0);
        run_expect("after_abort", 0);

        // Reset and Data_Valid together: the byte is dropped.
        RST            = 1'b1;
        bus.P_DATA     = 8'h5A;
        bus.Data_Valid = 1'b1;
        step();
        RST            = 1'b0;
        bus.Data_Valid = 1'b0;
        check("rst_vld.tx", 0, bus.TX_OUT, 1'b1);
        check("rst_vld.busy", 0, bus.Busy, 1'b0);
        step();
        check("rst_vld.tx", 1, bus.TX_OUT, 1'b1);
        check("rst_vld.busy", 1, bus.Busy, 1'b0);

        // Random frames with random idle gaps; parity from the count of ones.
        for (int r = 0; r < 25; r++) begin
            logic [W-1:0] d;
            bit           pen;
            bit           ptyp;
            int           gap;
            d    = W'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            add_frame(d, pen, 1'(($countones(d) % 2) ^ int'(ptyp)));
            push(1'b1, 1'b0);
            accept(d, pen, ptyp, 1'b0);
            run_expect($sformatf("rnd%0d", r), 0);
            check_int($sformatf("rnd%0d.busy_len", r), busy_cnt, pen ? W + 3 : W + 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit stage that drives the serial line consumed by the receiver's RX_IN input. It accepts one parallel byte per handshake and emits a frame: start bit, then Data_Width data bits LSB first, then an optional parity bit, then one stop bit. The block runs on the UART TX clock at one bit per clock cycle; oversampling is the receiver's concern. All outputs are registered.

Parameters:
Data_Width, 8, number of data bits per frame
B_C_W, $clog2(Data_Width), width of the data-bit index counter

Ports:
CLK  input  1  TX bit clock
RST  input  1  reset, synchronous, active-high
P_DATA  input  Data_Width  parallel byte to transmit
Data_Valid  input  1  P_DATA is valid; accepted only while Busy=0
PAR_EN  input  1  parity enable; sampled at acceptance
PAR_TYP  input  1  parity type, 0=even, 1=odd; sampled at acceptance
TX_OUT  output  1  serial line, idle high
Busy  output  1  frame in progress; upstream must hold off

Behaviour:
- Reset: RST is synchronous, active-high, sampled on the CLK rising edge. TX_OUT=1, Busy=0, state=IDLE, bit index=0, holding register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 at edge k, latch P_DATA, PAR_EN, PAR_TYP and the computed parity bit, then go to START.
- START (cycle k+1): TX_OUT=0, Busy=1. Clear the bit index. Go to DATA.
- DATA (cycles k+2 .. k+1+Data_Width): TX_OUT=data[index], index increments from 0. On the last bit (index=Data_Width-1), go to PARITY if the latched PAR_EN=1, else go to STOP.
- PARITY (cycle k+2+Data_Width): TX_OUT=parity bit, Busy=1. Go to STOP.
- STOP (cycle k+2+Data_Width, plus 1 if parity): TX_OUT=1, Busy=1. Go to IDLE.
- Busy is 1 exactly for the frame duration: 2+Data_Width cycles without parity, 3+Data_Width with parity.
- Parity bit: even = XOR-reduce of the latched data; odd = inverted XOR-reduce. It is computed from the latched byte only.
- Data_Valid while Busy=1 is ignored: no queuing, no effect on the frame in flight. Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect.
- Data_Valid held high continuously: the next byte is accepted on the IDLE cycle after STOP. Frames are separated by exactly one idle-high cycle.
- Data_Valid asserted in the same cycle the FSM enters IDLE from STOP: not accepted. Acceptance only occurs while state=IDLE at the clock edge.
- RST asserted mid-frame: the frame is aborted. The next edge gives TX_OUT=1, Busy=0, state IDLE. No partial-frame resume.
- RST and Data_Valid asserted together: reset wins and the byte is dropped.
- Outputs are glitch-free because TX_OUT and Busy are driven directly from flops.

Test Plan:
- Reset, then P_DATA=8'hA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 starting the cycle after acceptance; Busy high for exactly 10 cycles; TX_OUT=1 afterwards.
- 8'hA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0 after the 8 data bits, then stop 1, Busy high for 11 cycles. Repeat with PAR_TYP=1 -> parity bit 1.
- 8'h07, PAR_EN=1, PAR_TYP=0 -> parity bit 1. Change P_DATA to 8'hFF and PAR_EN to 0 mid-frame -> the transmitted frame is unchanged.
- Accept 8'h3C, then pulse Data_Valid with 8'hC3 during the DATA state -> only the 8'h3C frame is transmitted, and the line returns to idle high.
- Hold Data_Valid=1 with 8'h55 then 8'hAA, no parity -> two frames, with exactly one TX_OUT=1 idle cycle between the first stop bit and the second start bit.
- Assert RST for one cycle during data bit 4 of 8'h0F -> TX_OUT=1 and Busy=0 on the following edge; the next Data_Valid starts a clean frame.
